// File: rtl/nvme_perf_pkg.sv
// Shared register map and snapshot FSM encoding for the perf-counter snapshot reader.
package nvme_perf_pkg;

   localparam logic [11:0] CtrlAddr     = 12'h000;
   localparam logic [11:0] IntervalAddr = 12'h008;
   localparam logic [11:0] SeqAddr      = 12'h010;
   localparam logic [11:0] CtrBase      = 12'h100;
   localparam logic [11:0] CtrStride    = 12'h020;
   localparam logic [11:0] SumOff       = 12'h000;
   localparam logic [11:0] CompleteOff  = 12'h008;
   localparam logic [11:0] ActiveOff    = 12'h010;

   typedef enum logic [1:0] {
      StIdle,
      StCapt,
      StDone
   } snap_state_e;

endpackage

// File: rtl/nvme_perf_interval_timer.sv
// Free-running snapshot interval timer: counts 0..interval-1 and pulses o_expire on the last count.
module nvme_perf_interval_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wr_en,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_interval,
   output logic        o_expire
);

   logic [31:0] r_interval;
   logic [31:0] r_count;
   logic        w_expire;

   assign w_expire   = (r_interval != 32'd0) && (r_count == r_interval - 32'd1);
   assign o_expire   = w_expire;
   assign o_interval = r_interval;

   // A write both reprograms the period and restarts counting from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_interval <= 32'd0;
         r_count    <= 32'd0;
      end else if (i_wr_en) begin
         r_interval <= i_wdata;
         r_count    <= 32'd0;
      end else if (w_expire) begin
         r_count <= 32'd0;
      end else if (r_interval != 32'd0) begin
         r_count <= r_count + 32'd1;
      end
   end

endmodule

// File: rtl/nvme_perf_snapshot.sv
// Atomically samples the perf-counter bank, clears the interval sums, and serves frozen copies over MMIO.
module nvme_perf_snapshot
   import nvme_perf_pkg::*;
#(
   parameter int unsigned NumCtrs     = 4,
   parameter int unsigned SumWidth    = 64,
   parameter int unsigned ActiveWidth = 10
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NumCtrs*ActiveWidth-1:0]  i_ctr_active,
   input  logic [NumCtrs*SumWidth-1:0]     i_ctr_complete,
   input  logic [NumCtrs*SumWidth-1:0]     i_ctr_sum,
   output logic                            o_ctr_clr_sum,
   output logic                            o_ctr_clr,
   input  logic                            i_mmio_req_valid,
   output logic                            o_mmio_req_ready,
   input  logic                            i_mmio_req_wr,
   input  logic [11:0]                     i_mmio_req_addr,
   input  logic [63:0]                     i_mmio_req_wdata,
   output logic                            o_mmio_rsp_valid,
   output logic [63:0]                     o_mmio_rsp_data,
   output logic                            o_snap_busy
);

   snap_state_e             r_state;
   snap_state_e             w_state_nxt;
   logic                    r_snap_pend;
   logic                    r_clr_en;
   logic                    r_clr;
   logic [31:0]             r_seq;
   logic                    r_rsp_valid;
   logic [63:0]             r_rsp_data;
   logic [SumWidth-1:0]     r_snap_sum [NumCtrs];
   logic [SumWidth-1:0]     r_snap_cmp [NumCtrs];
   logic [ActiveWidth-1:0]  r_snap_act [NumCtrs];

   logic        w_accept;
   logic        w_wr;
   logic [11:0] w_word;
   logic        w_ctrl_wr;
   logic        w_int_wr;
   logic        w_snap_req;
   logic        w_expire;
   logic [31:0] w_interval;
   logic [63:0] w_rdata;
   logic        w_unused;

   assign w_word    = {i_mmio_req_addr[11:3], 3'b000};
   assign w_accept  = i_mmio_req_valid & o_mmio_req_ready;
   assign w_wr      = w_accept & i_mmio_req_wr;
   assign w_ctrl_wr = w_wr & (w_word == CtrlAddr);
   assign w_int_wr  = w_wr & (w_word == IntervalAddr);
   assign w_snap_req = (w_ctrl_wr & i_mmio_req_wdata[0]) | w_expire;
   assign w_unused  = ^{i_mmio_req_addr[2:0], i_mmio_req_wdata[63:32]};

   nvme_perf_interval_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (w_int_wr),
      .i_wdata    (i_mmio_req_wdata[31:0]),
      .o_interval (w_interval),
      .o_expire   (w_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (r_snap_pend) w_state_nxt = StCapt;
         StCapt:  w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      o_ctr_clr_sum    = (r_state == StCapt) & r_clr_en;
      o_snap_busy      = (r_state != StIdle);
      o_mmio_req_ready = (r_state == StIdle) & ~r_snap_pend & ~r_rsp_valid;
   end

   // Leaving IDLE consumes the pending flag; a request in that same cycle re-arms it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_snap_pend <= 1'b0;
         r_clr_en    <= 1'b1;
         r_clr       <= 1'b0;
         r_seq       <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 64'd0;
         for (int unsigned i = 0; i < NumCtrs; i++) begin
            r_snap_sum[i] <= '0;
            r_snap_cmp[i] <= '0;
            r_snap_act[i] <= '0;
         end
      end else begin
         r_snap_pend <= (r_snap_pend & (r_state != StIdle)) | w_snap_req;
         r_clr       <= w_ctrl_wr & i_mmio_req_wdata[2];
         r_rsp_valid <= w_accept;
         r_rsp_data  <= (w_accept & ~i_mmio_req_wr) ? w_rdata : 64'd0;
         if (w_ctrl_wr) r_clr_en <= i_mmio_req_wdata[1];
         if (r_state == StCapt) begin
            r_seq <= r_seq + 32'd1;
            for (int unsigned i = 0; i < NumCtrs; i++) begin
               r_snap_sum[i] <= i_ctr_sum[i*SumWidth +: SumWidth];
               r_snap_cmp[i] <= i_ctr_complete[i*SumWidth +: SumWidth];
               r_snap_act[i] <= i_ctr_active[i*ActiveWidth +: ActiveWidth];
            end
         end
      end
   end

   always_comb begin
      w_rdata = 64'd0;
      if (w_word == CtrlAddr)     w_rdata = {62'd0, r_clr_en, 1'b0};
      if (w_word == IntervalAddr) w_rdata = {32'd0, w_interval};
      if (w_word == SeqAddr)      w_rdata = {32'd0, r_seq};
      for (int unsigned i = 0; i < NumCtrs; i++) begin
         if (w_word[11:5] == 7'(CtrBase[11:5] + i)) begin
            if (w_word[4:0] == SumOff[4:0])      w_rdata = 64'(r_snap_sum[i]);
            if (w_word[4:0] == CompleteOff[4:0]) w_rdata = 64'(r_snap_cmp[i]);
            if (w_word[4:0] == ActiveOff[4:0])   w_rdata = 64'(r_snap_act[i]);
         end
      end
   end

   assign o_ctr_clr        = r_clr;
   assign o_mmio_rsp_valid = r_rsp_valid;
   assign o_mmio_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_nvme_perf_snapshot.sv
// Directed bench for nvme_perf_snapshot with two counter instances.
module tb_nvme_perf_snapshot;

   localparam int unsigned NumCtrs     = 2;
   localparam int unsigned SumWidth    = 64;
   localparam int unsigned ActiveWidth = 10;

   logic                           clk = 1'b0;
   logic                           reset;
   logic [NumCtrs*ActiveWidth-1:0] ctr_active;
   logic [NumCtrs*SumWidth-1:0]    ctr_complete;
   logic [NumCtrs*SumWidth-1:0]    ctr_sum;
   logic                           ctr_clr_sum;
   logic                           ctr_clr;
   logic                           req_valid;
   logic                           req_ready;
   logic                           req_wr;
   logic [11:0]                    req_addr;
   logic [63:0]                    req_wdata;
   logic                           rsp_valid;
   logic [63:0]                    rsp_data;
   logic                           snap_busy;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] rd;
   logic        rv;

   always #5 clk = ~clk;

   nvme_perf_snapshot #(
      .NumCtrs     (NumCtrs),
      .SumWidth    (SumWidth),
      .ActiveWidth (ActiveWidth)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .i_ctr_active     (ctr_active),
      .i_ctr_complete   (ctr_complete),
      .i_ctr_sum        (ctr_sum),
      .o_ctr_clr_sum    (ctr_clr_sum),
      .o_ctr_clr        (ctr_clr),
      .i_mmio_req_valid (req_valid),
      .o_mmio_req_ready (req_ready),
      .i_mmio_req_wr    (req_wr),
      .i_mmio_req_addr  (req_addr),
      .i_mmio_req_wdata (req_wdata),
      .o_mmio_rsp_valid (rsp_valid),
      .o_mmio_rsp_data  (rsp_data),
      .o_snap_busy      (snap_busy)
   );

   // Called at a negedge; returns at the negedge of the response cycle (T+1).
   task automatic mmio(input logic wr, input logic [11:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic rvalid);
      int n = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL mmio_ready_timeout addr=%h: ready=0 after 50 cycles, required 1", addr);
         req_valid = 1'b0;
         rdata     = 64'd0;
         rvalid    = 1'b0;
      end else begin
         @(posedge clk);
         #1 req_valid = 1'b0;
         @(negedge clk);
         rdata  = rsp_data;
         rvalid = rsp_valid;
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({ctr_clr_sum, ctr_clr, rsp_valid, snap_busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got clr_sum/clr/rsp_valid/busy=%b, required 0000",
                  {ctr_clr_sum, ctr_clr, rsp_valid, snap_busy});
      end
      checks++;
      if (rsp_data !== 64'd0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_rsp_ready: got data=%h ready=%b, required 0 and 1", rsp_data, req_ready);
      end
      mmio(1'b0, 12'h000, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'h2 || rv !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl: got %h valid=%b, required 2 valid=1", rd, rv);
      end
      mmio(1'b0, 12'h008, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd0) begin
         errors++;
         $display("FAIL reset_interval: got %h, required 0", rd);
      end
      mmio(1'b0, 12'h010, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd0) begin
         errors++;
         $display("FAIL reset_seq: got %h, required 0", rd);
      end
   endtask

   task automatic test_manual_snapshot;
      ctr_sum      = '0;
      ctr_complete = '0;
      ctr_active   = '0;
      ctr_sum[0 +: 64]      = 64'd100;
      ctr_complete[0 +: 64] = 64'd7;
      ctr_active[0 +: 10]   = 10'd3;
      ctr_sum[64 +: 64]     = 64'd55;
      mmio(1'b1, 12'h000, 64'h3, rd, rv);
      checks++;
      if (ctr_clr_sum !== 1'b0 || req_ready !== 1'b0 || rv !== 1'b1) begin
         errors++;
         $display("FAIL snap_t1: got clr_sum=%b ready=%b rsp_valid=%b, required 0 0 1",
                  ctr_clr_sum, req_ready, rv);
      end
      @(negedge clk);
      checks++;
      if (ctr_clr_sum !== 1'b1 || snap_busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL snap_t2_capt: got clr_sum=%b busy=%b ready=%b, required 1 1 0",
                  ctr_clr_sum, snap_busy, req_ready);
      end
      @(negedge clk);
      checks++;
      if (ctr_clr_sum !== 1'b0 || snap_busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL snap_t3_done: got clr_sum=%b busy=%b ready=%b, required 0 1 0",
                  ctr_clr_sum, snap_busy, req_ready);
      end
      @(negedge clk);
      checks++;
      if (snap_busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL snap_t4_idle: got busy=%b ready=%b, required 0 1", snap_busy, req_ready);
      end
      ctr_sum[0 +: 64] = 64'd999;
      mmio(1'b0, 12'h100, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd100) begin errors++; $display("FAIL snap_sum0: got %0d, required 100", rd); end
      mmio(1'b0, 12'h108, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd7) begin errors++; $display("FAIL snap_cmp0: got %0d, required 7", rd); end
      mmio(1'b0, 12'h110, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd3) begin errors++; $display("FAIL snap_act0: got %0d, required 3", rd); end
      mmio(1'b0, 12'h120, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd55) begin errors++; $display("FAIL snap_sum1: got %0d, required 55", rd); end
      mmio(1'b0, 12'h010, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd1) begin errors++; $display("FAIL snap_seq: got %0d, required 1", rd); end
   endtask

   task automatic test_clr_en_off;
      int pulses = 0;
      ctr_sum[0 +: 64]      = 64'd200;
      ctr_complete[0 +: 64] = 64'd9;
      mmio(1'b1, 12'h000, 64'h1, rd, rv);
      for (int k = 0; k < 4; k++) begin
         if (ctr_clr_sum) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL clren0_pulses: got %0d clr_sum pulses, required 0", pulses);
      end
      ctr_sum[0 +: 64]      = 64'd300;
      ctr_complete[0 +: 64] = 64'd11;
      mmio(1'b0, 12'h100, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd200) begin errors++; $display("FAIL clren0_sum0: got %0d, required 200", rd); end
      mmio(1'b0, 12'h108, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd9) begin errors++; $display("FAIL clren0_cmp0: got %0d, required 9", rd); end
      mmio(1'b0, 12'h000, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd0) begin errors++; $display("FAIL clren0_ctrl: got %h, required 0", rd); end
      mmio(1'b0, 12'h010, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd2) begin errors++; $display("FAIL clren0_seq: got %0d, required 2", rd); end
      mmio(1'b1, 12'h000, 64'h2, rd, rv);
   endtask

   task automatic test_interval;
      int pulses = 0;
      int first = -1;
      int last = -1;
      int bad_gap = 0;
      mmio(1'b1, 12'h008, 64'd20, rd, rv);
      for (int k = 1; k <= 105; k++) begin
         if (ctr_clr_sum) begin
            pulses++;
            if (first < 0) first = k;
            else if (k - last != 20) bad_gap++;
            last = k;
         end
         @(negedge clk);
      end
      checks++;
      if (pulses != 5 || first != 22) begin
         errors++;
         $display("FAIL interval_pulses: got %0d pulses first at %0d, required 5 first at 22",
                  pulses, first);
      end
      checks++;
      if (bad_gap != 0) begin
         errors++;
         $display("FAIL interval_spacing: got %0d gaps not 20 cycles, required 0", bad_gap);
      end
      mmio(1'b1, 12'h008, 64'd0, rd, rv);
      mmio(1'b0, 12'h010, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd7) begin errors++; $display("FAIL interval_seq: got %0d, required 7", rd); end
   endtask

   task automatic test_coalesce;
      mmio(1'b1, 12'h008, 64'd30, rd, rv);
      repeat (29) @(negedge clk);
      // Snap write lands in the same cycle the timer expires.
      mmio(1'b1, 12'h000, 64'h3, rd, rv);
      @(negedge clk);
      checks++;
      if (snap_busy !== 1'b1 || req_ready !== 1'b0 || ctr_clr_sum !== 1'b1) begin
         errors++;
         $display("FAIL coal_capt: got busy=%b ready=%b clr_sum=%b, required 1 0 1",
                  snap_busy, req_ready, ctr_clr_sum);
      end
      @(negedge clk);
      checks++;
      if (snap_busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL coal_done: got busy=%b ready=%b, required 1 0", snap_busy, req_ready);
      end
      @(negedge clk);
      checks++;
      if (snap_busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL coal_idle: got busy=%b ready=%b, required 0 1", snap_busy, req_ready);
      end
      mmio(1'b1, 12'h000, 64'h3, rd, rv);
      mmio(1'b1, 12'h008, 64'd0, rd, rv);
      mmio(1'b0, 12'h010, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd9) begin errors++; $display("FAIL coal_seq: got %0d, required 9", rd); end
   endtask

   task automatic test_decode_clear;
      logic [11:0] addrs [4];
      addrs[0] = 12'h160;
      addrs[1] = 12'h118;
      addrs[2] = 12'h018;
      addrs[3] = 12'h147;
      for (int k = 0; k < 4; k++) begin
         mmio(1'b0, addrs[k], 64'd0, rd, rv);
         checks++;
         if (rd !== 64'd0 || rv !== 1'b1) begin
            errors++;
            $display("FAIL decode_unmapped addr=%h: got %h valid=%b, required 0 valid=1",
                     addrs[k], rd, rv);
         end
      end
      mmio(1'b0, 12'h127, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd55) begin errors++; $display("FAIL decode_lowbits: got %0d, required 55", rd); end
      checks++;
      if (ctr_clr !== 1'b0) begin errors++; $display("FAIL clr_idle: got %b, required 0", ctr_clr); end
      mmio(1'b1, 12'h000, 64'h6, rd, rv);
      checks++;
      if (ctr_clr !== 1'b1 || rv !== 1'b1 || rd !== 64'd0) begin
         errors++;
         $display("FAIL clr_t1: got clr=%b valid=%b data=%h, required 1 1 0", ctr_clr, rv, rd);
      end
      @(negedge clk);
      checks++;
      if (ctr_clr !== 1'b0 || rsp_valid !== 1'b0 || snap_busy !== 1'b0) begin
         errors++;
         $display("FAIL clr_t2: got clr=%b rsp_valid=%b busy=%b, required 0 0 0",
                  ctr_clr, rsp_valid, snap_busy);
      end
   endtask

   task automatic test_reset_midop;
      ctr_sum[0 +: 64] = 64'h1234;
      mmio(1'b1, 12'h000, 64'h1, rd, rv);
      @(negedge clk);
      checks++;
      if (snap_busy !== 1'b1) begin
         errors++;
         $display("FAIL midop_capt: got busy=%b, required 1", snap_busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({ctr_clr_sum, ctr_clr, rsp_valid, snap_busy} !== 4'b0000 || rsp_data !== 64'd0) begin
         errors++;
         $display("FAIL midop_outputs: got clr_sum/clr/rsp_valid/busy=%b data=%h, required 0000 0",
                  {ctr_clr_sum, ctr_clr, rsp_valid, snap_busy}, rsp_data);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (snap_busy !== 1'b0 || ctr_clr_sum !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_resume: got busy=%b clr_sum=%b, required 0 0",
                     snap_busy, ctr_clr_sum);
         end
      end
      mmio(1'b0, 12'h010, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd0) begin errors++; $display("FAIL midop_seq: got %0d, required 0", rd); end
      mmio(1'b0, 12'h000, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'h2) begin errors++; $display("FAIL midop_ctrl: got %h, required 2", rd); end
      mmio(1'b0, 12'h100, 64'd0, rd, rv);
      checks++;
      if (rd !== 64'd0) begin errors++; $display("FAIL midop_sum0: got %h, required 0", rd); end
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_wr       = 1'b0;
      req_addr     = 12'd0;
      req_wdata    = 64'd0;
      ctr_active   = '0;
      ctr_complete = '0;
      ctr_sum      = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_manual_snapshot();
      test_clr_en_off();
      test_interval();
      test_coalesce();
      test_decode_clear();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
